mem_refill_arbiter: RTL and testbench

//   Shares one main-memory port between the I-cache refill path and the D-cache refill/write-back path.

---
 rtl/mem_refill_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_refill_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_arbiter.sv
// Shares one memory port between I-cache refill and D-cache refill/write-back line bursts.
// Build macro MEMARB_FIXED_PRIO_EN gives the D side fixed priority instead of round-robin.
module mem_refill_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         i_req,
  input  logic [AW-1:0]                i_addr,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [AW-1:0]                d_addr,
  input  logic [DW-1:0]                d_wdata,
  output logic                         mem_valid,
  output logic                         mem_we,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  input  logic                         mem_ready,
  input  logic [DW-1:0]                mem_rdata,
  output logic                         i_gnt,
  output logic                         d_gnt,
  output logic [$clog2(BURST_LEN)-1:0] beat_idx,
  output logic                         rvalid,
  output logic [DW-1:0]                rdata,
  output logic                         i_done,
  output logic                         d_done,
  output logic                         stall
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int OFS = BW + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [BW-1:0] beat_r, beat_s;
  logic [AW-1:0] base_r, base_s;
  logic          we_r, we_s;
  logic          gnt_d_r, gnt_d_s;
  logic          last_d_r, last_d_s;
  logic          pick_d_s;
  logic          in_burst_s;
  logic          owned_s;

  function automatic logic [AW-1:0] line_base(input logic [AW-1:0] addr);
    line_base = {addr[AW-1:OFS], {OFS{1'b0}}};
  endfunction

  // Arbitration winner when leaving IDLE
  always_comb begin
`ifdef MEMARB_FIXED_PRIO_EN
    pick_d_s = d_req;
`else
    pick_d_s = d_req & (~i_req | ~last_d_r);
`endif
  end

  // Next-state logic: burst sequencing and latching of the granted request
  always_comb begin
    state_s  = state_r;
    beat_s   = beat_r;
    base_s   = base_r;
    we_s     = we_r;
    gnt_d_s  = gnt_d_r;
    last_d_s = last_d_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req | d_req) begin
          state_s = ST_BURST;
          beat_s  = '0;
          gnt_d_s = pick_d_s;
          base_s  = pick_d_s ? line_base(d_addr) : line_base(i_addr);
          we_s    = pick_d_s & d_we;
        end else begin
          beat_s = '0;
        end
      end
      ST_BURST: begin
        if (mem_ready) begin
          if (beat_r == LAST_BEAT) begin
            state_s = ST_DONE;
            beat_s  = '0;
          end else begin
            beat_s = beat_r + 1'b1;
          end
        end else begin
          beat_s = beat_r;
        end
      end
      ST_DONE: begin
        state_s  = ST_IDLE;
        last_d_s = gnt_d_r;
      end
      default: begin
        state_s = ST_IDLE;
        beat_s  = '0;
      end
    endcase
  end

  // State, beat counter and latched burst context
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_r  <= ST_IDLE;
      beat_r   <= '0;
      base_r   <= '0;
      we_r     <= 1'b0;
      gnt_d_r  <= 1'b0;
      last_d_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      beat_r   <= beat_s;
      base_r   <= base_s;
      we_r     <= we_s;
      gnt_d_r  <= gnt_d_s;
      last_d_r <= last_d_s;
    end
  end

  assign in_burst_s = (state_r == ST_BURST);
  assign owned_s    = (state_r != ST_IDLE);

  assign mem_valid = in_burst_s;
  assign mem_we    = in_burst_s & we_r;
  assign mem_addr  = in_burst_s ? (base_r | {{(AW-OFS){1'b0}}, beat_r, 2'b00}) : '0;
  assign mem_wdata = d_wdata;
  assign i_gnt     = owned_s & ~gnt_d_r;
  assign d_gnt     = owned_s & gnt_d_r;
  assign beat_idx  = beat_r;
  assign rvalid    = mem_valid & mem_ready & ~mem_we;
  assign rdata     = rvalid ? mem_rdata : '0;
  assign i_done    = (state_r == ST_DONE) & ~gnt_d_r;
  assign d_done    = (state_r == ST_DONE) & gnt_d_r;
  assign stall     = (i_req & ~i_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mem_refill_arbiter;

  logic        clk;
  logic        RST;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_valid, mem_we, i_gnt, d_gnt, rvalid, i_done, d_done, stall;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [1:0]  beat_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic first_d;

  mem_refill_arbiter #(.AW(32), .DW(32), .BURST_LEN(4)) dut (
    .clk(clk), .RST(RST),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .beat_idx(beat_idx),
    .rvalid(rvalid), .rdata(rdata), .i_done(i_done), .d_done(d_done), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr, dwe, rdy;
    logic [31:0] ia, da;
    logic        ev, ewe;
    logic [31:0] ea;
    logic        eig, edg, eid, edd, erv, est;
    logic [1:0]  eb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ir, dr, dwe, rdy, input logic [31:0] ia, da,
                              input logic ev, ewe, input logic [31:0] ea,
                              input logic eig, edg, eid, edd, erv, est, input logic [1:0] eb);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dwe = dwe; v.rdy = rdy; v.ia = ia; v.da = da;
    v.ev = ev; v.ewe = ewe; v.ea = ea; v.eig = eig; v.edg = edg;
    v.eid = eid; v.edd = edd; v.erv = erv; v.est = est; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for the done pulse of one side, then drop that side's request.
  task automatic wait_done(input string nm, input logic want_d);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (want_d ? d_done : i_done) begin
        seen = 1'b1;
        if (want_d) d_req = 1'b0;
        else        i_req = 1'b0;
      end
    end
    chk(nm, 74'(seen), 74'(1'b1));
  endtask

  initial begin
    logic [31:0] pat;
    RST = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;

    // both requests after reset: D first (last grant reset to I), then I
    vq.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h1000,32'h2004, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0));
    for (int b = 0; b < 4; b++)
      vq.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h1000,32'h2004, 1'b1,1'b0,32'h2000+32'(4*b), 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 2'(b)));
    vq.push_back(mk(1'b1,1'b1,1'b0,1'b1, 32'h1000,32'h2004, 1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 2'd0));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h1000,32'h2004, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0));
    for (int b = 0; b < 4; b++)
      vq.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h1000,32'h2004, 1'b1,1'b0,32'h1000+32'(4*b), 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 2'(b)));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h1000,32'h2004, 1'b0,1'b0,32'h0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b1, 32'h1000,32'h2004, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0));
    // I refill alone, unaligned address 0x104C
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h104C,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0));
    for (int b = 0; b < 4; b++)
      vq.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h104C,32'h0, 1'b1,1'b0,32'h1040+32'(4*b), 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 2'(b)));
    vq.push_back(mk(1'b1,1'b0,1'b0,1'b1, 32'h104C,32'h0, 1'b0,1'b0,32'h0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b1, 32'h104C,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0));
    // D refill; req dropped and addr/we changed from beat 1 on, latched values must persist
    vq.push_back(mk(1'b0,1'b1,1'b0,1'b1, 32'h0,32'h3014, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0));
    vq.push_back(mk(1'b0,1'b1,1'b0,1'b1, 32'h0,32'h3014, 1'b1,1'b0,32'h3010, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 2'd0));
    for (int b = 1; b < 4; b++)
      vq.push_back(mk(1'b0,1'b0,1'b1,1'b1, 32'h0,32'hFFFF_FFF0, 1'b1,1'b0,32'h3010+32'(4*b), 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 2'(b)));
    vq.push_back(mk(1'b0,1'b0,1'b1,1'b1, 32'h0,32'hFFFF_FFF0, 1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'd0));
    vq.push_back(mk(1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0, 1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {mem_valid, mem_we, mem_addr, i_gnt, d_gnt, i_done, d_done, rvalid, beat_idx, rdata, 1'b0},
        74'h0);
    RST = 1'b1;

    for (int r = 0; r < vq.size(); r++) begin
      @(negedge clk);
      i_req = vq[r].ir; d_req = vq[r].dr; d_we = vq[r].dwe; mem_ready = vq[r].rdy;
      i_addr = vq[r].ia; d_addr = vq[r].da;
      pat = {16'hC0DE, r[15:0]};
      mem_rdata = pat;
      #1;
      chk($sformatf("vec%0d", r),
          {mem_valid, mem_we, mem_addr, i_gnt, d_gnt, i_done, d_done, rvalid, stall, beat_idx, rdata},
          {vq[r].ev, vq[r].ewe, vq[r].ea, vq[r].eig, vq[r].edg, vq[r].eid, vq[r].edd, vq[r].erv,
           vq[r].est, vq[r].eb, (vq[r].erv ? pat : 32'h0)});
    end

    // write-back with mem_ready low for 3 cycles on beat 2
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_0001; mem_ready = 1'b1;
    #1; chk("t2_idle_stall", 74'(stall), 74'(1'b1));
    @(negedge clk); #1;
    chk("t2_b0", {mem_valid, mem_we, rvalid, mem_addr, mem_wdata, 8'h0}, {1'b1, 1'b1, 1'b0, 32'h2000, 32'hDEAD_0001, 8'h0});
    @(negedge clk); #1;
    chk("t2_b1", 74'(mem_addr), 74'(32'h2004));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk($sformatf("t2_hold%0d", k), {mem_valid, mem_we, beat_idx, mem_addr, d_done, 37'h0},
          {1'b1, 1'b1, 2'd2, 32'h2008, 1'b0, 37'h0});
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1; chk("t2_hold_rel", {mem_we, beat_idx, mem_addr}, 74'({1'b1, 2'd2, 32'h2008}));
    @(negedge clk); #1;
    chk("t2_b3", {beat_idx, mem_addr}, 74'({2'd3, 32'h200C}));
    @(negedge clk); #1;
    chk("t2_done", {d_done, i_done, mem_valid, stall}, 74'({1'b1, 1'b0, 1'b0, 1'b0}));
    d_req = 1'b0; d_we = 1'b0;

    // both requesting with last grant = D
`ifdef MEMARB_FIXED_PRIO_EN
    first_d = 1'b1;
`else
    first_d = 1'b0;
`endif
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4000; d_req = 1'b1; d_addr = 32'h6000;
    @(negedge clk); #1;
    chk("arb_first", {i_gnt, d_gnt, mem_addr}, 74'({~first_d, first_d, (first_d ? 32'h6000 : 32'h4000)}));
    wait_done("arb_first_done", first_d);
    @(negedge clk); #1;
    chk("arb_dead_cycle", {mem_valid, i_gnt, d_gnt}, 74'h0);
    @(negedge clk); #1;
    chk("arb_second", {i_gnt, d_gnt, mem_addr}, 74'({first_d, ~first_d, (first_d ? 32'h4000 : 32'h6000)}));
    wait_done("arb_second_done", ~first_d);

    // asynchronous reset in the middle of beat 2
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h5000;
    repeat (3) @(negedge clk);
    #1; chk("t5_pre", {i_gnt, beat_idx, mem_addr}, 74'({1'b1, 2'd2, 32'h5008}));
    #1; RST = 1'b0;
    #1; chk("t5_in_reset", {mem_valid, mem_we, mem_addr, i_gnt, d_gnt, i_done, d_done, rvalid, beat_idx, rdata, 1'b0},
            74'h0);
    @(negedge clk);
    RST = 1'b1;
    #1; chk("t5_idle", {mem_valid, i_gnt, stall}, 74'({1'b0, 1'b0, 1'b1}));
    @(negedge clk); #1;
    chk("t5_restart", {mem_valid, i_gnt, beat_idx, mem_addr}, 74'({1'b1, 1'b1, 2'd0, 32'h5000}));
    wait_done("t5_done", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
